// File: rtl/dac_jesd204_tx_framer.sv
// JESD204 TX sample framer: buffers DMA sample words in a FIFO and maps them onto the lane bus,
// octet-swapped and paced by tx_ready. Optional ramp source via DAC_JESD204_TX_PATTERN_EN.
module dac_jesd204_tx_framer #(
  parameter int unsigned NUM_LANES       = 1,
  parameter int unsigned NUM_CHANNELS    = 1,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned PRIME_LEVEL     = 4,
  parameter int unsigned TWOS_COMPLEMENT = 1
) (
  input  logic                      tx_clk,
  input  logic                      tx_rstn,
  input  logic [NUM_CHANNELS-1:0]   dac_enable,
  input  logic                      dac_valid,
  output logic                      dac_ready,
  input  logic [32*NUM_LANES-1:0]   dac_data,
  output logic                      dac_dunf,
  input  logic                      unf_clear,
  output logic [15:0]               unf_count,
  output logic [1:0]                tx_state,
`ifdef DAC_JESD204_TX_PATTERN_EN
  input  logic                      pattern_sel,
`endif
  input  logic                      tx_ready,
  output logic [32*NUM_LANES-1:0]   tx_data
);

  localparam int unsigned W  = 32 * NUM_LANES;
  localparam int unsigned NS = 2 * NUM_LANES;
  localparam int unsigned D  = NS / NUM_CHANNELS;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPrime = 2'b01,
    StRun   = 2'b10
  } state_e;

  state_e          r_state, w_state_d;
  logic [W-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, w_wptr_d;
  logic [AW-1:0]   r_rptr, w_rptr_d;
  logic [LW-1:0]   r_level, w_level_d;
  logic            r_ready, w_ready_d;
  logic            r_dunf;
  logic [15:0]     r_unf_cnt;
  logic [W-1:0]    r_tx_data;

  logic            w_any_en;
  logic            w_push;
  logic            w_beat_run;
  logic            w_empty;
  logic            w_pop;
  logic            w_unf;
  logic            w_flush;
  logic [W-1:0]    w_rd_word;
  logic [W-1:0]    w_src_word;

  // Channel-major input word to slot-interleaved, octet-swapped lane data.
  function automatic logic [W-1:0] frame_word(input logic [W-1:0]            word,
                                              input logic [NUM_CHANNELS-1:0] en);
    logic [W-1:0] out;
    logic [15:0]  smp;
    int unsigned  slot;
    out = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      for (int unsigned s = 0; s < D; s++) begin
        slot = s * NUM_CHANNELS + c;
        smp  = word[(c*D+s)*16 +: 16];
        if (TWOS_COMPLEMENT == 0) smp[15] = ~smp[15];
        if (!en[c]) smp = '0;
        out[slot*16 +: 8]   = smp[15:8];
        out[slot*16+8 +: 8] = smp[7:0];
      end
    end
    return out;
  endfunction

  assign w_any_en   = |dac_enable;
  assign w_push     = dac_valid && r_ready;
  assign w_beat_run = (r_state == StRun) && tx_ready;
  assign w_empty    = (r_level == '0);
  assign w_pop      = w_beat_run && !w_empty;
  assign w_unf      = w_beat_run && w_empty;
  assign w_flush    = !w_any_en || (r_state == StIdle);
  assign w_rd_word  = r_mem[r_rptr];

`ifdef DAC_JESD204_TX_PATTERN_EN
  logic [15:0]  r_ramp;
  logic [W-1:0] w_ramp_word;

  always_comb begin
    w_ramp_word = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      for (int unsigned s = 0; s < D; s++) begin
        w_ramp_word[(c*D+s)*16 +: 16] = r_ramp + 16'(s);
      end
    end
  end

  // Ramp restarts whenever RUN is re-entered.
  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      r_ramp <= '0;
    end else if (r_state != StRun) begin
      r_ramp <= '0;
    end else if (w_pop && pattern_sel) begin
      r_ramp <= r_ramp + 16'(D);
    end
  end

  assign w_src_word = pattern_sel ? w_ramp_word : w_rd_word;
`else
  assign w_src_word = w_rd_word;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_en) w_state_d = StPrime;
      StPrime: if (r_level >= LW'(PRIME_LEVEL)) w_state_d = StRun;
      StRun:   if (w_unf) w_state_d = StPrime;
      default: w_state_d = StIdle;
    endcase
    if (!w_any_en) w_state_d = StIdle;
  end

  always_comb begin
    w_level_d = r_level;
    w_wptr_d  = r_wptr;
    w_rptr_d  = r_rptr;
    if (w_flush) begin
      w_level_d = '0;
      w_wptr_d  = '0;
      w_rptr_d  = '0;
    end else begin
      if (w_push) w_wptr_d = r_wptr + AW'(1);
      if (w_pop)  w_rptr_d = r_rptr + AW'(1);
      if (w_push && !w_pop) w_level_d = r_level + LW'(1);
      if (!w_push && w_pop) w_level_d = r_level - LW'(1);
    end
    w_ready_d = (w_level_d < LW'(FIFO_DEPTH)) && (w_state_d != StIdle);
  end

  always_ff @(posedge tx_clk) begin
    if (w_push) r_mem[r_wptr] <= dac_data;
  end

  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      r_state <= StIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
      r_dunf  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wptr  <= w_wptr_d;
      r_rptr  <= w_rptr_d;
      r_level <= w_level_d;
      r_ready <= w_ready_d;
      r_dunf  <= w_unf;
    end
  end

  // Clear has priority over a coincident underflow increment.
  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      r_unf_cnt <= '0;
    end else if (unf_clear) begin
      r_unf_cnt <= '0;
    end else if (w_unf && (r_unf_cnt != 16'hFFFF)) begin
      r_unf_cnt <= r_unf_cnt + 16'd1;
    end
  end

  // Holds between link beats; any non-pop beat sends zeros.
  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      r_tx_data <= '0;
    end else if (tx_ready) begin
      r_tx_data <= w_pop ? frame_word(w_src_word, dac_enable) : '0;
    end
  end

  assign dac_ready = r_ready;
  assign dac_dunf  = r_dunf;
  assign unf_count = r_unf_cnt;
  assign tx_state  = r_state;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_dac_jesd204_tx_framer.sv
// Directed bench for dac_jesd204_tx_framer: three configurations driven in turn from one
// initial block, each step compared against hand-computed lane words.
module tb_dac_jesd204_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // 1 lane, 1 channel, two's complement
  logic [0:0]  en1;
  logic        valid1, ready1, dunf1, clr1, txr1;
  logic [31:0] data1, txd1;
  logic [15:0] cnt1;
  logic [1:0]  st1;

  // 2 lanes, 2 channels
  logic [1:0]  en2;
  logic        valid2, ready2, dunf2, clr2, txr2;
  logic [63:0] data2, txd2;
  logic [15:0] cnt2;
  logic [1:0]  st2;

  // 1 lane, 2 channels, offset binary
  logic [1:0]  en3;
  logic        valid3, ready3, dunf3, clr3, txr3;
  logic [31:0] data3, txd3;
  logic [15:0] cnt3;
  logic [1:0]  st3;

`ifdef DAC_JESD204_TX_PATTERN_EN
  logic pat1 = 1'b0;
  logic pat2 = 1'b0;
  logic pat3 = 1'b0;
`endif

  dac_jesd204_tx_framer #(
    .NUM_LANES(1), .NUM_CHANNELS(1), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .TWOS_COMPLEMENT(1)
  ) u_dut1 (
    .tx_clk(clk), .tx_rstn(rstn), .dac_enable(en1), .dac_valid(valid1), .dac_ready(ready1),
    .dac_data(data1), .dac_dunf(dunf1), .unf_clear(clr1), .unf_count(cnt1), .tx_state(st1),
`ifdef DAC_JESD204_TX_PATTERN_EN
    .pattern_sel(pat1),
`endif
    .tx_ready(txr1), .tx_data(txd1)
  );

  dac_jesd204_tx_framer #(
    .NUM_LANES(2), .NUM_CHANNELS(2), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .TWOS_COMPLEMENT(1)
  ) u_dut2 (
    .tx_clk(clk), .tx_rstn(rstn), .dac_enable(en2), .dac_valid(valid2), .dac_ready(ready2),
    .dac_data(data2), .dac_dunf(dunf2), .unf_clear(clr2), .unf_count(cnt2), .tx_state(st2),
`ifdef DAC_JESD204_TX_PATTERN_EN
    .pattern_sel(pat2),
`endif
    .tx_ready(txr2), .tx_data(txd2)
  );

  dac_jesd204_tx_framer #(
    .NUM_LANES(1), .NUM_CHANNELS(2), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .TWOS_COMPLEMENT(0)
  ) u_dut3 (
    .tx_clk(clk), .tx_rstn(rstn), .dac_enable(en3), .dac_valid(valid3), .dac_ready(ready3),
    .dac_data(data3), .dac_dunf(dunf3), .unf_clear(clr3), .unf_count(cnt3), .tx_state(st3),
`ifdef DAC_JESD204_TX_PATTERN_EN
    .pattern_sel(pat3),
`endif
    .tx_ready(txr3), .tx_data(txd3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wl [12] = '{32'h56781234, 32'hA1B2C3D4, 32'h00FF8001, 32'hCAFEBEEF,
                           32'h01020304, 32'h11223344, 32'h55667788, 32'h99AABBCC,
                           32'hDDEEFF00, 32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single-lane single-channel mapping: each 16-bit half has its octets swapped.
  function automatic logic [31:0] swap1(input logic [31:0] w);
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    en1 = '0; valid1 = 0; data1 = '0; clr1 = 0; txr1 = 0;
    en2 = '0; valid2 = 0; data2 = '0; clr2 = 0; txr2 = 0;
    en3 = '0; valid3 = 0; data3 = '0; clr3 = 0; txr3 = 0;
    #12;
    chk("rst_state", 64'(st1), 64'h0);
    chk("rst_ready", 64'(ready1), 64'h0);
    chk("rst_dunf", 64'(dunf1), 64'h0);
    chk("rst_count", 64'(cnt1), 64'h0);
    chk("rst_txdata", 64'(txd1), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    en1 = 1'b1; txr1 = 1'b1;
    step;
    chk("idle_to_prime", 64'(st1), 64'h1);
    chk("prime_ready", 64'(ready1), 64'h1);

    // Prime with four words, then stream them out.
    valid1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data1 = wl[k];
      step;
    end
    valid1 = 1'b0;
    chk("prime_hold", 64'(st1), 64'h1);
    step;
    chk("prime_to_run", 64'(st1), 64'h2);
    chk("prime_zero", 64'(txd1), 64'h0);
    step;
    chk("tp1_word0", 64'(txd1), 64'h78563412);
    step;
    chk("word1", 64'(txd1), 64'hB2A1D4C3);
    step;
    chk("word2", 64'(txd1), 64'hFF000180);
    step;
    chk("word3", 64'(txd1), 64'hFECAEFBE);
    chk("no_dunf_yet", 64'(dunf1), 64'h0);

    // Empty beat in RUN: underflow.
    step;
    chk("unf_zero", 64'(txd1), 64'h0);
    chk("unf_pulse", 64'(dunf1), 64'h1);
    chk("unf_count1", 64'(cnt1), 64'h1);
    chk("unf_to_prime", 64'(st1), 64'h1);
    step;
    chk("unf_one_cycle", 64'(dunf1), 64'h0);
    chk("unf_count_hold", 64'(cnt1), 64'h1);

    // Backpressure: fill the FIFO to 8 with the link stalled.
    txr1 = 1'b0;
    valid1 = 1'b1;
    for (int k = 4; k < 12; k++) begin
      data1 = wl[k];
      step;
    end
    chk("full_ready_low", 64'(ready1), 64'h0);
    chk("full_state_run", 64'(st1), 64'h2);
    data1 = 32'hDEADDEAD;
    step;
    step;
    chk("full_ready_stays", 64'(ready1), 64'h0);
    valid1 = 1'b0;
    txr1 = 1'b1;
    step;
    chk("drain_w4", 64'(txd1), 64'(swap1(wl[4])));
    txr1 = 1'b0;
    step;
    step;
    chk("stall_hold", 64'(txd1), 64'(swap1(wl[4])));
    txr1 = 1'b1;
    for (int k = 5; k < 12; k++) begin
      step;
      chk("drain_order", 64'(txd1), 64'(swap1(wl[k])));
    end
    step;
    chk("drain_unf_pulse", 64'(dunf1), 64'h1);
    chk("drain_unf_count", 64'(cnt1), 64'h2);
    clr1 = 1'b1;
    step;
    clr1 = 1'b0;
    chk("unf_clear", 64'(cnt1), 64'h0);

    // Drop enables mid-RUN.
    txr1 = 1'b0;
    valid1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data1 = wl[k];
      step;
    end
    valid1 = 1'b0;
    step;
    chk("rerun", 64'(st1), 64'h2);
    txr1 = 1'b1;
    step;
    chk("rerun_w0", 64'(txd1), 64'h78563412);
    en1 = 1'b0;
    step;
    chk("dis_idle", 64'(st1), 64'h0);
    chk("dis_ready", 64'(ready1), 64'h0);
    step;
    chk("dis_zero", 64'(txd1), 64'h0);
    en1 = 1'b1;
    txr1 = 1'b0;
    step;
    valid1 = 1'b1;
    for (int k = 4; k < 7; k++) begin
      data1 = wl[k];
      step;
    end
    valid1 = 1'b0;
    step;
    step;
    chk("flushed_prime", 64'(st1), 64'h1);
    valid1 = 1'b1;
    data1 = wl[7];
    step;
    valid1 = 1'b0;
    step;
    chk("flushed_run", 64'(st1), 64'h2);
    txr1 = 1'b1;
    step;
    chk("flushed_first", 64'(txd1), 64'(swap1(wl[4])));
    step;
    step;
    step;
    step;
    chk("unf_again", 64'(cnt1), 64'h1);

    // Reset pulse mid-stream.
    txr1 = 1'b0;
    valid1 = 1'b1;
    for (int k = 8; k < 12; k++) begin
      data1 = wl[k];
      step;
    end
    valid1 = 1'b0;
    step;
    txr1 = 1'b1;
    step;
    chk("pre_rst_word", 64'(txd1), 64'(swap1(wl[8])));
    rstn = 1'b0;
    #2;
    chk("arst_state", 64'(st1), 64'h0);
    chk("arst_ready", 64'(ready1), 64'h0);
    chk("arst_txdata", 64'(txd1), 64'h0);
    chk("arst_count", 64'(cnt1), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    step;
    chk("post_rst_prime", 64'(st1), 64'h1);
    txr1 = 1'b0;
    step;
    chk("post_rst_empty", 64'(st1), 64'h1);
    en1 = 1'b0;

    // Two lanes, two channels.
    en2 = 2'b11;
    txr2 = 1'b1;
    step;
    valid2 = 1'b1;
    data2 = 64'h0B0B0A0A_00020001;
    for (int k = 0; k < 4; k++) step;
    valid2 = 1'b0;
    step;
    chk("l2_run", 64'(st2), 64'h2);
    step;
    chk("tp2_interleave", txd2, 64'h0B0B0200_0A0A0100);
    en2 = 2'b01;
    step;
    chk("l2_ch1_off", txd2, 64'h00000200_00000100);
    en2 = 2'b00;
    step;
    chk("l2_idle", 64'(st2), 64'h0);

    // Offset binary, one lane, two channels.
    en3 = 2'b11;
    step;
    valid3 = 1'b1;
    data3 = 32'h0; step;
    data3 = 32'h0; step;
    data3 = 32'h1234_8001; step;
    data3 = 32'h0; step;
    valid3 = 1'b0;
    step;
    chk("ob_run", 64'(st3), 64'h2);
    txr3 = 1'b1;
    step;
    chk("ob_zero", 64'(txd3), 64'h0080_0080);
    en3 = 2'b01;
    step;
    chk("ob_disabled", 64'(txd3), 64'h0000_0080);
    en3 = 2'b11;
    step;
    chk("ob_value", 64'(txd3), 64'h3492_0100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_jesd204_tx_framer.md
# dac_jesd204_tx_framer

Transmit-side sample framer for JESD204 DAC paths. It accepts parallel per-channel sample words from the DMA/DDS side through a valid/ready handshake and buffers them in a small FIFO. It interleaves and octet-maps the samples onto the link-layer lane bus and paces output by the link layer's `tx_ready`. It sits between the DAC DMA interface and the JESD204 TX link layer, mirroring the ADC receive interface on the transmit end.

## Interface
- `NUM_LANES`, 1: JESD204 lanes; bus width W = 32*NUM_LANES.
- `NUM_CHANNELS`, 1: converter channels; must divide 2*NUM_LANES.
- `FIFO_DEPTH`, 8: FIFO words, power of two, 4..64.
- `PRIME_LEVEL`, 4: FIFO level needed to leave PRIME, 1..FIFO_DEPTH.
- `TWOS_COMPLEMENT`, 1: 1 = pass samples unchanged; 0 = invert sample MSB (offset binary).
- `tx_clk  in  1`: link clock (line-rate/40), the only clock.
- `tx_rstn  in  1`: reset, asynchronous and active-low; all state and outputs clear on assertion.
- `dac_enable  in  NUM_CHANNELS`: per-channel enable; disabled channels transmit 0.
- `dac_valid  in  1`: source word valid.
- `dac_ready  out  1`: framer accepts the word.
- `dac_data  in  W`: channel-major 16-bit samples; channel c, sample s at `[(c*D+s)*16 +: 16]`, where D = 2*NUM_LANES/NUM_CHANNELS.
- `dac_dunf  out  1`: one-cycle pulse per underflowed beat.
- `unf_clear  in  1`: synchronous clear of `unf_count`.
- `unf_count  out  16`: saturating underflow counter.
- `tx_state  out  2`: 00 IDLE, 01 PRIME, 10 RUN.
- `tx_ready  in  1`: link layer consumes `tx_data` this cycle.
- `tx_data  out  W`: framed lane data.

## Operation
- FIFO push on `dac_valid && dac_ready`. `dac_ready` = (level < FIFO_DEPTH) && state != IDLE, registered from the next-state level.
- Pop only in RUN on a `tx_ready` cycle with level > 0. Simultaneous push and pop leave the level unchanged.
- Framing of a popped word: output slot i = s*NUM_CHANNELS + c takes sample (c,s). Each slot is octet-swapped: `tx_data[i*16 +: 8]` = sample[15:8] and `tx_data[i*16+8 +: 8]` = sample[7:0]. When TWOS_COMPLEMENT=0, sample bit 15 is inverted before mapping. A disabled channel's slots are 0 and are not inverted.
- FSM:
  - IDLE: entered when `dac_enable` == 0. FIFO flushed, `tx_data` = 0. Leaves to PRIME when any enable is set.
  - PRIME: `tx_data` = 0; no pops. Moves to RUN when level >= PRIME_LEVEL.
  - RUN: pops each `tx_ready` cycle. A `tx_ready` cycle with level == 0 is an underflow:
    - `tx_data` = 0 for that beat
    - `dac_dunf` pulses
    - `unf_count` increments (saturates at 0xFFFF)
    - state moves to PRIME
- Enables dropping to 0 in any state moves to IDLE next cycle, flushes the FIFO, and zeroes `tx_data` from the following `tx_ready` beat.
- `unf_clear` wins over a simultaneous increment; the result is 0.

## Timing
- Reset values: `dac_ready`=0, `dac_dunf`=0, `unf_count`=0, `tx_state`=00, `tx_data`=0.
- `tx_data` is registered and updates only on `tx_ready` cycles; it holds otherwise.
- Latency: a word popped at edge N appears on `tx_data` after edge N. A push at edge N is poppable at edge N+1. Minimum push-to-`tx_data` latency is 2 cycles.
- The PRIME→RUN transition is taken on the edge after the level reaches PRIME_LEVEL. The first pop is on the next `tx_ready` cycle.
- `dac_dunf` is asserted the cycle after the empty `tx_ready` cycle and lasts exactly one cycle.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge. Deassertion takes effect at the next `tx_clk` edge.

## Configuration
- `DAC_JESD204_TX_PATTERN_EN` defined:
  - Adds input `pattern_sel` (1 bit).
  - When `pattern_sel`=1 in RUN, each `tx_ready` beat sends a per-channel 16-bit ramp instead of FIFO data. The ramp starts at 0 on entry to RUN and increments by 1 per sample, in sample order s. FIFO pops continue, so the handshake is unchanged.
  - Framing, TWOS_COMPLEMENT handling and the enable gating apply to the ramp.
- Not defined: no port, no ramp logic; data always comes from the FIFO.

## Test plan
- NUM_LANES=1, NUM_CHANNELS=1, `tx_ready`=1, push 0x1234/0x5678 → after 4 primed words, `tx_data` = 0x78563412.
- NUM_LANES=2, NUM_CHANNELS=2, ch0 = {0x0001,0x0002}, ch1 = {0x0A0A,0x0B0B} → `tx_data` = 0x0B0B0200_0A0A0100.
- TWOS_COMPLEMENT=0, sample 0x0000 → slot = 0x0080; same with the channel disabled → 0x0000.
- RUN, stop `dac_valid` until empty → one beat of 0, `dac_dunf` pulses once, `unf_count`=1, `tx_state`=01; refill 4 words → RUN.
- `tx_ready` held 0 with source pushing → `dac_ready` falls at level 8, no data lost; release `tx_ready` → words come out in order.
- Clear `dac_enable` mid-RUN and pulse `tx_rstn` mid-stream → IDLE, zeros on `tx_data`, FIFO empty, `unf_count`=0 after reset.
